// File: rtl/bcd_scan_display.sv
// Time-multiplexed common-anode 7-segment driver: shadowed BCD capture, round-robin digit scan
// with a blank guard at each slot start. Define BCD_SCAN_LZ_BLANK_EN for leading-zero blanking.
module bcd_scan_display #(
  parameter int DIGITS       = 4,
  parameter int SLOT_CYCLES  = 50000,
  parameter int GUARD_CYCLES = 2
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [4*DIGITS-1:0]   BCD,
  input  logic [DIGITS-1:0]     DOTS,
  input  logic                  LOAD,
  input  logic                  EN,
  output logic [7:0]            SEG,
  output logic [DIGITS-1:0]     DIG,
  output logic                  SLOT_DONE
);

  localparam int CNT_W = $clog2(SLOT_CYCLES);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [4*DIGITS-1:0] shadow_reg;
  logic [DIGITS-1:0]   dots_reg;
  logic [CNT_W-1:0]    slot_cnt_reg;
  logic [IDX_W-1:0]    idx_reg;
  logic [7:0]          seg_reg, seg_next;
  logic [DIGITS-1:0]   dig_reg, dig_next;
  logic                slot_done_reg, slot_done_next;

  logic                cnt_last;
  logic                idx_last;
  logic                in_guard;
  logic [3:0]          cur_code;
  logic                cur_dot;

  assign cnt_last = (slot_cnt_reg == CNT_W'(SLOT_CYCLES - 1));
  assign idx_last = (idx_reg == IDX_W'(DIGITS - 1));
  assign cur_code = shadow_reg[{idx_reg, 2'b00} +: 4];
  assign cur_dot  = dots_reg[idx_reg];

  generate
    if (GUARD_CYCLES == 0) begin : g_no_guard
      assign in_guard = 1'b0;
    end else begin : g_guard
      assign in_guard = (slot_cnt_reg < CNT_W'(GUARD_CYCLES));
    end
  endgenerate

`ifdef BCD_SCAN_LZ_BLANK_EN
  // A digit is blanked when it and every more significant digit are zero; digit 0 always shows.
  logic [DIGITS-1:0] lz_blank;
  logic              cur_blank;

  assign lz_blank[0] = 1'b0;
  for (genvar gi = 1; gi < DIGITS; gi++) begin : g_lz
    assign lz_blank[gi] = ~|shadow_reg[4*DIGITS-1:4*gi];
  end
  assign cur_blank = lz_blank[idx_reg];
`endif

  // Segment order {a,b,c,d,e,f,g}, active-low.
  function automatic logic [6:0] seg_decode(input logic [3:0] code);
    logic [6:0] s;
    case (code)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  always_comb begin
    seg_next       = {cur_dot, 7'b1111111};
    dig_next       = '1;
    slot_done_next = EN && idx_last && cnt_last;
    if (EN && !in_guard) begin
      dig_next[idx_reg] = 1'b0;
`ifdef BCD_SCAN_LZ_BLANK_EN
      seg_next[6:0] = cur_blank ? 7'b1111111 : seg_decode(cur_code);
`else
      seg_next[6:0] = seg_decode(cur_code);
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      shadow_reg    <= '1;
      dots_reg      <= '0;
      slot_cnt_reg  <= '0;
      idx_reg       <= '0;
      seg_reg       <= 8'b0111_1111;
      dig_reg       <= '1;
      slot_done_reg <= 1'b0;
    end else begin
      if (LOAD) begin
        shadow_reg <= BCD;
        dots_reg   <= DOTS;
      end
      if (EN) begin
        if (cnt_last) begin
          slot_cnt_reg <= '0;
          idx_reg      <= idx_last ? '0 : idx_reg + 1'b1;
        end else begin
          slot_cnt_reg <= slot_cnt_reg + 1'b1;
        end
      end
      seg_reg       <= seg_next;
      dig_reg       <= dig_next;
      slot_done_reg <= slot_done_next;
    end
  end

  assign SEG       = seg_reg;
  assign DIG       = dig_reg;
  assign SLOT_DONE = slot_done_reg;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Bench for bcd_scan_display (DIGITS=4, SLOT_CYCLES=4, GUARD_CYCLES=1): table-driven BCD patterns
// plus hand-written reset, enable-freeze and back-to-back load sequences, scored cycle by cycle.
module tb_bcd_scan_display;

  localparam int ND = 4;
  localparam int NS = 4;
  localparam int NG = 1;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic [15:0]   BCD = 16'h0;
  logic [3:0]    DOTS = 4'h0;
  logic          LOAD = 1'b0;
  logic          EN = 1'b0;
  logic [7:0]    SEG;
  logic [3:0]    DIG;
  logic          SLOT_DONE;

  bcd_scan_display #(.DIGITS(ND), .SLOT_CYCLES(NS), .GUARD_CYCLES(NG)) dut (
    .CLK(CLK), .RST_N(RST_N), .BCD(BCD), .DOTS(DOTS), .LOAD(LOAD), .EN(EN),
    .SEG(SEG), .DIG(DIG), .SLOT_DONE(SLOT_DONE)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [7:0] seg;
    logic [3:0] dig;
    logic       done;
  } exp_t;

  // Expected full SEG byte per digit, written as {digit3, digit2, digit1, digit0}.
  typedef struct packed {
    logic [15:0]     bcd;
    logic [3:0]      dots;
    logic [3:0][7:0] seg;
  } vec_t;

  exp_t            sb_q[$];
  vec_t            vecs[8];
  int              checks = 0;
  int              errors = 0;
  int              cyc = 0;
  int              m_cnt = 0;
  int              m_idx = 0;
  logic [3:0][7:0] cur_seg = {4{8'h7F}};
  logic [3:0][7:0] pend_seg = {4{8'h7F}};
  string           phase = "reset";

  task automatic step(input logic r, input logic ld, input logic en);
    exp_t e;
    exp_t got;
    RST_N = r;
    LOAD  = ld;
    EN    = en;
    if (!r) begin
      e.seg = 8'h7F; e.dig = 4'hF; e.done = 1'b0;
    end else begin
      e.done = en && (m_idx == ND - 1) && (m_cnt == NS - 1);
      if (!en || m_cnt < NG) begin
        e.dig = 4'hF;
        e.seg = {cur_seg[m_idx][7], 7'h7F};
      end else begin
        e.dig = 4'hF & ~(4'b0001 << m_idx);
        e.seg = cur_seg[m_idx];
      end
    end
    sb_q.push_back(e);
    if (!r) begin
      m_cnt = 0; m_idx = 0; cur_seg = {4{8'h7F}};
    end else begin
      if (ld) cur_seg = pend_seg;
      if (en) begin
        if (m_cnt == NS - 1) begin
          m_cnt = 0;
          m_idx = (m_idx + 1) % ND;
        end else begin
          m_cnt = m_cnt + 1;
        end
      end
    end
    @(posedge CLK);
    #1;
    got = {SEG, DIG, SLOT_DONE};
    e = sb_q.pop_front();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL %s cyc %0d: got seg=%h dig=%b done=%b, want seg=%h dig=%b done=%b",
               phase, cyc, got.seg, got.dig, got.done, e.seg, e.dig, e.done);
    end
    cyc++;
  endtask

  task automatic apply_vec(input int i);
    BCD      = vecs[i].bcd;
    DOTS     = vecs[i].dots;
    pend_seg = vecs[i].seg;
  endtask

  initial begin
    vecs[0] = '{16'h1234, 4'b0100, {8'h4F, 8'h92, 8'h06, 8'h4C}};
    vecs[1] = '{16'hABCF, 4'b0000, {8'h7F, 8'h7F, 8'h7F, 8'h7F}};
    vecs[2] = '{16'h5678, 4'b1001, {8'hA4, 8'h20, 8'h0F, 8'h80}};
    vecs[3] = '{16'h9090, 4'b0000, {8'h04, 8'h01, 8'h04, 8'h01}};
    vecs[4] = '{16'hDE00, 4'b0000, {8'h7F, 8'h7F, 8'h01, 8'h01}};
`ifdef BCD_SCAN_LZ_BLANK_EN
    vecs[5] = '{16'h0000, 4'b0000, {8'h7F, 8'h7F, 8'h7F, 8'h01}};
    vecs[6] = '{16'h0050, 4'b0010, {8'h7F, 8'h7F, 8'hA4, 8'h01}};
    vecs[7] = '{16'h0000, 4'b1111, {8'hFF, 8'hFF, 8'hFF, 8'h81}};
`else
    vecs[5] = '{16'h0000, 4'b0000, {8'h01, 8'h01, 8'h01, 8'h01}};
    vecs[6] = '{16'h0050, 4'b0010, {8'h01, 8'h01, 8'hA4, 8'h01}};
    vecs[7] = '{16'h0000, 4'b1111, {8'h81, 8'h81, 8'h81, 8'h81}};
`endif

    phase = "reset";
    repeat (3) step(1'b0, 1'b0, 1'b0);
    phase = "reset_over_load";
    apply_vec(0);
    step(1'b0, 1'b1, 1'b1);

    for (int i = 0; i < 8; i++) begin
      phase = $sformatf("vec%0d_%h", i, vecs[i].bcd);
      apply_vec(i);
      step(1'b1, 1'b1, 1'b1);
      repeat (2 * ND * NS) step(1'b1, 1'b0, 1'b1);
    end

    phase = "load_every_cycle";
    for (int k = 0; k < 12; k++) begin
      apply_vec((k % 2 == 0) ? 0 : 2);
      step(1'b1, 1'b1, 1'b1);
    end

    phase = "en_freeze";
    for (int k = 0; k < NS && m_cnt != 2; k++) step(1'b1, 1'b0, 1'b1);
    repeat (5) step(1'b1, 1'b0, 1'b0);
    repeat (ND * NS) step(1'b1, 1'b0, 1'b1);

    phase = "reset_mid_scan";
    for (int k = 0; k < 2 * ND * NS && !(m_idx == 2 && m_cnt == 2); k++)
      step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    phase = "after_reset";
    repeat (ND * NS + 2) step(1'b1, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
